// File: rtl/fixed_div_pkg.sv
// fixed_div_pkg
//   Shared definitions for the sequential fixed-point divider:
//   - state_t        : divider FSM state encoding
//   - clog2()        : counter width helper (minimum 1 bit)
//   - sat_max/sat_min: two's complement extremes for a given width, returned
//                      as 64-bit values (widths up to 64 bits are supported)
package fixed_div_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Largest positive value: 0x7F..F
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative value: 0x80..0
  function automatic logic [63:0] sat_min(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/fixed_div_seq_udiv_step.sv
// udiv_step
//   One combinational radix-2 restoring division step on unsigned values.
//   Shifts the next dividend bit into the partial remainder, then subtracts
//   the divisor when it fits.
// Ports
//   r_in    W  partial remainder from the previous step (always < divisor)
//   d_bit   1  next dividend bit, msb first
//   divisor W  unsigned divisor magnitude
//   r_out   W  new partial remainder
//   q_bit   1  quotient bit produced by this step
module udiv_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] r_in,
  input  logic         d_bit,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] r_out,
  output logic         q_bit
);

  logic [W:0] r_sh;
  logic [W:0] diff;

  // r_in < divisor <= 2^(W-1), so the shifted value never exceeds W bits of
  // magnitude and the remainder fits back into W bits either way.
  always_comb begin
    r_sh  = {r_in, d_bit};
    diff  = r_sh - {1'b0, divisor};
    q_bit = (r_sh >= {1'b0, divisor});
    r_out = W'(q_bit ? diff : r_sh);
  end

endmodule

// File: rtl/fixed_div_seq.sv
// fixed_div_seq
//   Sequential signed fixed-point divider, res = a / b, all values in
//   Q(W-FRAC-1).FRAC two's complement. One quotient bit per clock via
//   restoring long division on magnitudes, then sign and saturation fix-up.
//   FSM: IDLE -> LOAD -> DIV (W+FRAC cycles) -> FIX -> DONE -> IDLE.
// Ports
//   clk    in   1  clock, rising edge
//   rst_n  in   1  synchronous active-low reset
//   start  in   1  request, sampled only in IDLE
//   a      in   W  dividend
//   b      in   W  divisor
//   busy   out  1  high in LOAD, DIV and FIX
//   done   out  1  one-cycle pulse in DONE; res/ovf/dz valid
//   res    out  W  quotient truncated toward zero, held until next result
//   ovf    out  1  quotient saturated
//   dz     out  1  divisor was zero
module fixed_div_seq
  import fixed_div_pkg::*;
#(
  parameter int W    = 32,
  parameter int FRAC = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] res,
  output logic         ovf,
  output logic         dz
);

  localparam int               ITER     = W + FRAC;
  localparam int               CNT_W    = clog2(ITER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);
  localparam logic [W-1:0]     POS_SAT  = W'(sat_max(W));
  localparam logic [W-1:0]     NEG_SAT  = W'(sat_min(W));

  state_t state, state_nxt;

  logic signed [W-1:0] a_p0, b_p0;
  logic                sign_p1;
  logic                dz_p1;
  logic [W-1:0]        bmag_p1;
  logic [W-1:0]        rem_p1;
  logic [ITER-1:0]     dvd_p1;
  logic [ITER-1:0]     quo_p1;
  logic [CNT_W-1:0]    cnt_p1;
  logic [W-1:0]        rem_step;
  logic                q_step;

  // Unsigned magnitude. W bits are enough: negating 0x80..0 in W bits gives
  // 2^(W-1) read as unsigned, which is exact.
  function automatic logic [W-1:0] mag(input logic signed [W-1:0] v);
    logic [W-1:0] u;
    u = v;
    return v[W-1] ? (~u + 1'b1) : u;
  endfunction

  // Apply sign and saturate the ITER-bit magnitude; returns {ovf, res}.
  // Positive range tops out at 2^(W-1)-1, negative range at 2^(W-1).
  function automatic logic [W:0] fix_result(input logic [ITER-1:0] q,
                                            input logic            neg);
    logic [ITER:0] qx;
    logic [W-1:0]  ql;
    logic          over_pos;
    logic          over_neg;
    qx       = {1'b0, q};
    ql       = q[W-1:0];
    over_pos = |qx[ITER:W-1];
    over_neg = (|qx[ITER:W]) | (q[W-1] & (|q[W-2:0]));
    if (neg)
      return over_neg ? {1'b1, NEG_SAT} : {1'b0, ~ql + 1'b1};
    else
      return over_pos ? {1'b1, POS_SAT} : {1'b0, ql};
  endfunction

  udiv_step #(.W(W)) u_step (
    .r_in   (rem_p1),
    .d_bit  (dvd_p1[ITER-1]),
    .divisor(bmag_p1),
    .r_out  (rem_step),
    .q_bit  (q_step)
  );

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: if (start) state_nxt = LOAD;
      LOAD: begin
        busy      = 1'b1;
        state_nxt = DIV;
      end
      DIV: begin
        busy = 1'b1;
        if (cnt_p1 == CNT_LAST) state_nxt = FIX;
      end
      FIX: begin
        busy      = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state and the visible result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      res   <= '0;
      ovf   <= 1'b0;
      dz    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == FIX) begin
        dz <= dz_p1;
        if (dz_p1) begin
          res <= a_p0[W-1] ? NEG_SAT : POS_SAT;
          ovf <= 1'b0;
        end else begin
          {ovf, res} <= fix_result(quo_p1, sign_p1);
        end
      end
    end
  end

  // Operand capture (p0) and iteration datapath (p1); LOAD always
  // initialises p1 before DIV reads it, so no reset is needed here.
  always_ff @(posedge clk) begin
    unique case (state)
      IDLE: begin
        if (start) begin
          a_p0 <= a;
          b_p0 <= b;
        end
      end
      LOAD: begin
        sign_p1 <= a_p0[W-1] ^ b_p0[W-1];
        bmag_p1 <= mag(b_p0);
        dvd_p1  <= ITER'(mag(a_p0)) << FRAC;
        rem_p1  <= '0;
        quo_p1  <= '0;
        cnt_p1  <= '0;
        dz_p1   <= (b_p0 == '0);
      end
      DIV: begin
        // A zero divisor still iterates; FIX discards the quotient.
        rem_p1 <= rem_step;
        dvd_p1 <= dvd_p1 << 1;
        quo_p1 <= {quo_p1[ITER-2:0], q_step};
        cnt_p1 <= cnt_p1 + 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fixed_div_seq.sv
// tb_fixed_div_seq
//   Self-checking bench for fixed_div_seq at W=32, FRAC=15. A reference
//   timeline/arithmetic model predicts busy/done/res/ovf/dz every cycle;
//   directed cases add literal expectations.
module tb_fixed_div_seq;

  localparam int W    = 32;
  localparam int FRAC = 15;
  localparam int ITER = W + FRAC;
  localparam int LAT  = ITER + 3;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] res;
  logic         ovf;
  logic         dz;

  int total = 0;
  int bad   = 0;

  fixed_div_seq #(.W(W), .FRAC(FRAC)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .busy (busy),
    .done (done),
    .res  (res),
    .ovf  (ovf),
    .dz   (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
    end
  endtask

  // Reference arithmetic: exact signed division with truncation toward zero
  function automatic void ref_div(input logic [31:0] xa, input logic [31:0] xb,
                                  output logic [31:0] r, output logic o, output logic d);
    longint na, nb, q;
    na = longint'($signed(xa));
    nb = longint'($signed(xb));
    o  = 1'b0;
    d  = (nb == 0);
    if (d) begin
      r = (na < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      q = (na * 64'sd32768) / nb;
      if (q > 64'sd2147483647) begin
        r = 32'h7FFF_FFFF; o = 1'b1;
      end else if (q < -64'sd2147483648) begin
        r = 32'h8000_0000; o = 1'b1;
      end else begin
        r = q[31:0];
      end
    end
  endfunction

  // Timeline model: ph=0 idle, 1..LAT-1 busy, LAT is the done cycle
  int           ph = 0;
  logic [31:0]  pa, pb;
  logic [31:0]  e_res = '0;
  logic         e_ovf = 1'b0;
  logic         e_dz  = 1'b0;
  bit           chk_en = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      ph = 0; e_res = '0; e_ovf = 1'b0; e_dz = 1'b0; chk_en = 1'b1;
    end else if (ph == 0) begin
      if (start) begin ph = 1; pa = a; pb = b; end
    end else if (ph == LAT) begin
      ph = 0;
    end else begin
      ph++;
      if (ph == LAT) ref_div(pa, pb, e_res, e_ovf, e_dz);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(ph >= 1 && ph < LAT));
      chk("done", 32'(done), 32'(ph == LAT));
      chk("res",  res, e_res);
      chk("ovf",  32'(ovf), 32'(e_ovf));
      chk("dz",   32'(dz),  32'(e_dz));
    end
  end

  task automatic run_op(input logic [31:0] xa, input logic [31:0] xb, output int lat);
    @(negedge clk);
    start = 1'b1; a = xa; b = xb;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic dir_op(input string nm, input logic [31:0] xa, input logic [31:0] xb,
                        input logic [31:0] r, input logic o, input logic d);
    int lat;
    run_op(xa, xb, lat);
    chk({nm, "_lat"}, 32'(lat), 32'(LAT));
    chk({nm, "_res"}, res, r);
    chk({nm, "_ovf"}, 32'(ovf), 32'(o));
    chk({nm, "_dz"},  32'(dz),  32'(d));
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] mr;
    logic        mo, md;
    logic [31:0] xa, xb;
    int          lat, nd, sh;
    int          st[3];

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;

    // Pin the reference model to hand-computed values
    ref_div(32'h0001_8000, 32'h0001_0000, mr, mo, md);
    chk("model_3div2", mr, 32'h0000_C000);
    ref_div(32'h0000_8000, 32'hFFFE_8000, mr, mo, md);
    chk("model_1divm3", mr, 32'hFFFF_D556);
    ref_div(32'h4000_0000, 32'h0000_0001, mr, mo, md);
    chk("model_ovf", {mr[30:0], mo}, {31'h7FFF_FFFF, 1'b1});
    ref_div(32'hFFFF_8000, 32'h0000_0000, mr, mo, md);
    chk("model_dz", {mr[30:0], md}, {31'h0000_0000, 1'b1});

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_res",  res, 32'd0);
    chk("rst_flags", {30'd0, ovf, dz}, 32'd0);
    rst_n = 1'b1;

    dir_op("t1",  32'h0001_8000, 32'h0001_0000, 32'h0000_C000, 1'b0, 1'b0);
    dir_op("t2a", 32'hFFFF_8000, 32'h0002_0000, 32'hFFFF_E000, 1'b0, 1'b0);
    dir_op("t2b", 32'h0000_8000, 32'hFFFE_8000, 32'hFFFF_D556, 1'b0, 1'b0);
    dir_op("t3a", 32'h0000_8000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1);
    dir_op("t3b", 32'hFFFF_8000, 32'h0000_0000, 32'h8000_0000, 1'b0, 1'b1);
    dir_op("t3c", 32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1);
    dir_op("t4a", 32'h4000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0);
    dir_op("t4b", 32'h8000_0000, 32'h0000_8000, 32'h8000_0000, 1'b0, 1'b0);
    dir_op("t4c", 32'h8000_0000, 32'hFFFF_8000, 32'h7FFF_FFFF, 1'b1, 1'b0);
    dir_op("t4d", 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_0000, 1'b0, 1'b0);

    // start held high with operands changing every cycle
    nd = 0;
    st[0] = -1000; st[1] = -1000; st[2] = -1000;
    @(negedge clk);
    start = 1'b1; a = $urandom; b = $urandom;
    for (int c = 1; c <= 200 && nd < 3; c++) begin
      @(negedge clk);
      if (done) begin st[nd] = c; nd++; end
      if (nd < 3) begin a = $urandom; b = $urandom >> $urandom_range(0, 24); end
    end
    start = 1'b0;
    chk("b2b_count", 32'(nd), 32'd3);
    chk("b2b_period1", 32'(st[1] - st[0]), 32'(ITER + 4));
    chk("b2b_period2", 32'(st[2] - st[1]), 32'(ITER + 4));

    // Randomised operations
    for (int i = 0; i < 30; i++) begin
      xa = $urandom;
      sh = $urandom_range(0, 31);
      xb = $urandom >> sh;
      if ($urandom_range(0, 1) == 1) xb = -xb;
      if (i % 10 == 3) xb = '0;
      if (i % 10 == 5) xa = 32'h8000_0000;
      if (i % 10 == 7) xa = xa >> $urandom_range(8, 31);
      run_op(xa, xb, lat);
      chk("rnd_lat", 32'(lat), 32'(LAT));
    end

    // Reset in the middle of DIV
    @(negedge clk);
    start = 1'b1; a = 32'h0003_0000; b = 32'h0000_4000;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_res",  res, 32'd0);
    chk("mid_rst_flags", {30'd0, ovf, dz}, 32'd0);
    repeat (3) @(negedge clk);
    chk("post_rst_idle", 32'(busy), 32'd0);
    dir_op("t6", 32'h0001_8000, 32'h0001_0000, 32'h0000_C000, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
